// File: rtl/buzzer_arbiter_if.sv
// rtl/buzzer_arbiter_if.sv - tone-source side bundle of the buzzer arbiter
// Requests and half-periods flow in; grant, busy and the square wave flow out.
interface buzzer_arbiter_if #(
  parameter int NUM_REQ = 3,
  parameter int HP_W    = 16
);
  logic [NUM_REQ-1:0]      req;
  logic [NUM_REQ*HP_W-1:0] half_period;
  logic [NUM_REQ-1:0]      gnt;
  logic                    busy;
  logic                    speaker;
  logic                    buzzer;

  modport master (output req, half_period, input gnt, busy, speaker, buzzer);
  modport slave  (input req, half_period, output gnt, busy, speaker, buzzer);
endinterface

// File: rtl/buzzer_arbiter.sv
// rtl/buzzer_arbiter.sv - fixed-priority buzzer sharing with silent gap and square-wave generation
// Optional BUZZ_PREEMPT_EN: a higher-priority request releases the current owner.
module buzzer_arbiter #(
  parameter int NUM_REQ    = 3,
  parameter int HP_W       = 16,
  parameter int GAP_CYCLES = 50000
) (
  input  logic              sys_clk,
  input  logic              rst_n,
  buzzer_arbiter_if.slave   bus
);
  localparam int IW     = $clog2(NUM_REQ);
  localparam int GW_RAW = $clog2(GAP_CYCLES + 1);
  localparam int GW     = (GW_RAW < 1) ? 1 : GW_RAW;
  localparam logic [GW-1:0] GAP_LAST = GW'((GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_PLAY = 2'd1;
  localparam logic [1:0] S_GAP  = 2'd2;

  logic [1:0]         state_q, state_d;
  logic [NUM_REQ-1:0] gnt_q, gnt_d;
  logic [IW-1:0]      idx_q, idx_d;
  logic               speaker_q, speaker_d;
  logic [HP_W-1:0]    cnt_q, cnt_d;
  logic [HP_W-1:0]    hp_q, hp_d;
  logic [GW-1:0]      gap_q, gap_d;

  logic [IW-1:0]      win_idx;
  logic [HP_W-1:0]    win_hp;
  logic [HP_W-1:0]    own_hp;
  logic               hi_req;

  always_comb begin
    win_idx = '0;
    for (int i = NUM_REQ - 1; i >= 0; i--) begin
      if (bus.req[i]) win_idx = IW'(i);
    end
    win_hp = bus.half_period[win_idx*HP_W +: HP_W];
    own_hp = bus.half_period[idx_q*HP_W +: HP_W];
    hi_req = 1'b0;
`ifdef BUZZ_PREEMPT_EN
    for (int j = 0; j < NUM_REQ; j++) begin
      if (j < int'(idx_q) && bus.req[j]) hi_req = 1'b1;
    end
`endif
  end

  always_comb begin
    state_d   = state_q;
    gnt_d     = gnt_q;
    idx_d     = idx_q;
    speaker_d = speaker_q;
    cnt_d     = cnt_q;
    hp_d      = hp_q;
    gap_d     = gap_q;
    case (state_q)
      S_IDLE: begin
        if (|bus.req) begin
          gnt_d     = NUM_REQ'(1) << win_idx;
          idx_d     = win_idx;
          hp_d      = win_hp;
          cnt_d     = '0;
          speaker_d = 1'b0;
          state_d   = S_PLAY;
        end
      end
      S_PLAY: begin
        // Release outranks any tone edge due in the same cycle.
        if (!bus.req[idx_q] || hi_req) begin
          gnt_d     = '0;
          speaker_d = 1'b0;
          cnt_d     = '0;
          gap_d     = '0;
          state_d   = (GAP_CYCLES > 0) ? S_GAP : S_IDLE;
        end else if (hp_q == '0) begin
          speaker_d = 1'b0;
          cnt_d     = '0;
          hp_d      = own_hp;
        end else if (cnt_q == hp_q - HP_W'(1)) begin
          // New half-period only taken at a toggle, so note changes never glitch.
          speaker_d = ~speaker_q;
          cnt_d     = '0;
          hp_d      = own_hp;
        end else begin
          cnt_d = cnt_q + HP_W'(1);
        end
      end
      S_GAP: begin
        if (gap_q == GAP_LAST) begin
          gap_d   = '0;
          state_d = S_IDLE;
        end else begin
          gap_d = gap_q + GW'(1);
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge sys_clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_IDLE;
      gnt_q     <= '0;
      idx_q     <= '0;
      speaker_q <= 1'b0;
      cnt_q     <= '0;
      hp_q      <= '0;
      gap_q     <= '0;
    end else begin
      state_q   <= state_d;
      gnt_q     <= gnt_d;
      idx_q     <= idx_d;
      speaker_q <= speaker_d;
      cnt_q     <= cnt_d;
      hp_q      <= hp_d;
      gap_q     <= gap_d;
    end
  end

  assign bus.gnt     = gnt_q;
  assign bus.busy    = (state_q != S_IDLE);
  assign bus.speaker = speaker_q;
  assign bus.buzzer  = speaker_q;
endmodule
